// File: rtl/snn_pkg.sv
// rtl/snn_pkg.sv - shared spike widths and packet layout for the wrapper and spike path
package snn_pkg;

    localparam int NEURON_ID_W = 8;
    localparam int WEIGHT_W    = 8;

    // Spike packet layout on the wrapper side: ID in the low byte, weight above it
    localparam int SPIKE_ID_LSB  = 0;
    localparam int SPIKE_ID_MSB  = 7;
    localparam int SPIKE_WT_LSB  = 8;
    localparam int SPIKE_WT_MSB  = 15;
    localparam int SPIKE_PKT_W   = 16;

    typedef struct packed {
        logic [WEIGHT_W-1:0]    weight;
        logic [NEURON_ID_W-1:0] neuron_id;
    } spike_pkt_t;

    function automatic spike_pkt_t pack_spike(input logic [NEURON_ID_W-1:0] id,
                                              input logic [WEIGHT_W-1:0] wt);
        spike_pkt_t p;
        p.neuron_id = id;
        p.weight    = wt;
        return p;
    endfunction

endpackage

// File: rtl/snn_sync_fifo.sv
// rtl/snn_sync_fifo.sv - generic first-word-fall-through FIFO with wrap-bit pointers
module snn_sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   fill_level
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             push;
    logic             pop;

    assign empty      = (wr_ptr == rd_ptr);
    assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign fill_level = wr_ptr - rd_ptr;

    // Head data is masked while empty so stale storage never shows on the output
    assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

    assign push = wr_en & ~full & ~flush;
    assign pop  = rd_en & ~empty & ~flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/spike_input_buffer.sv
// rtl/spike_input_buffer.sv - range-filtered spike queue between the AXI wrapper and router
module spike_input_buffer
    import snn_pkg::*;
#(
    parameter int DEPTH           = 16,
    parameter int NUM_NEURONS     = 64,
    parameter int NEURON_ID_WIDTH = NEURON_ID_W,
    parameter int WEIGHT_WIDTH    = WEIGHT_W
) (
    input  logic                       s_axi_aclk,
    input  logic                       s_axi_aresetn,
    input  logic                       enable,
    input  logic                       flush,
    input  logic                       clr_stats,
    input  logic                       in_valid,
    input  logic [NEURON_ID_WIDTH-1:0] in_neuron_id,
    input  logic [WEIGHT_WIDTH-1:0]    in_weight,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [NEURON_ID_WIDTH-1:0] out_neuron_id,
    output logic [WEIGHT_WIDTH-1:0]    out_weight,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     fill_level,
    output logic                       full,
    output logic                       empty,
    output logic [31:0]                accepted_count,
    output logic [15:0]                drop_count
);

    localparam int W = NEURON_ID_WIDTH + WEIGHT_WIDTH;

    logic         in_range;
    logic         handshake;
    logic         store;
    logic         drop;
    logic [W-1:0] head;

    assign in_range  = (32'(in_neuron_id) < NUM_NEURONS);
    // Reset gating keeps the wrapper from seeing a consume while the block is held in reset
    assign in_ready  = s_axi_aresetn & enable & ~flush & ~full;
    assign handshake = in_valid & in_ready;
    assign store     = handshake & in_range;
    assign drop      = handshake & ~in_range;

    assign out_valid = ~empty;
    assign {out_weight, out_neuron_id} = head;

    snn_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (W)
    ) u_fifo (
        .clk        (s_axi_aclk),
        .rst_n      (s_axi_aresetn),
        .flush      (flush),
        .wr_en      (store),
        .wr_data    ({in_weight, in_neuron_id}),
        .rd_en      (out_ready),
        .rd_data    (head),
        .full       (full),
        .empty      (empty),
        .fill_level (fill_level)
    );

    // clr_stats wins over a coincident increment
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            accepted_count <= '0;
            drop_count     <= '0;
        end else if (clr_stats) begin
            accepted_count <= '0;
            drop_count     <= '0;
        end else begin
            if (store) accepted_count <= accepted_count + 32'd1;
            if (drop && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_spike_input_buffer.sv
// tb/tb_spike_input_buffer.sv - directed self-checking bench for spike_input_buffer
module tb_spike_input_buffer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic       flush;
    logic       clr_stats;
    logic       in_valid;
    logic [7:0] in_neuron_id;
    logic [7:0] in_weight;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_neuron_id;
    logic [7:0] out_weight;
    logic       out_ready;
    logic [4:0] fill_level;
    logic       full;
    logic       empty;
    logic [31:0] accepted_count;
    logic [15:0] drop_count;

    int passed = 0;
    int total  = 0;
    int exp_acc = 0;

    always #5 clk = ~clk;

    spike_input_buffer #(
        .DEPTH(16), .NUM_NEURONS(64), .NEURON_ID_WIDTH(8), .WEIGHT_WIDTH(8)
    ) dut (
        .s_axi_aclk     (clk),
        .s_axi_aresetn  (rst_n),
        .enable         (enable),
        .flush          (flush),
        .clr_stats      (clr_stats),
        .in_valid       (in_valid),
        .in_neuron_id   (in_neuron_id),
        .in_weight      (in_weight),
        .in_ready       (in_ready),
        .out_valid      (out_valid),
        .out_neuron_id  (out_neuron_id),
        .out_weight     (out_weight),
        .out_ready      (out_ready),
        .fill_level     (fill_level),
        .full           (full),
        .empty          (empty),
        .accepted_count (accepted_count),
        .drop_count     (drop_count)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_n(input int n, input int id0, input int wt0);
        in_valid = 1'b1;
        for (int i = 0; i < n; i++) begin
            in_neuron_id = 8'(id0 + i);
            in_weight    = 8'(wt0 + i);
            step();
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; enable = 1'b1; flush = 1'b0; clr_stats = 1'b0;
        in_valid = 1'b1; in_neuron_id = 8'd1; in_weight = 8'd2; out_ready = 1'b0;
        #12;
        total++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready got %0b want 0", in_ready); else passed++;
        total++; if (out_valid !== 1'b0 || empty !== 1'b1 || full !== 1'b0 || fill_level !== 5'd0)
            $display("FAIL reset_status got v%0b e%0b f%0b l%0d want v0 e1 f0 l0", out_valid, empty, full, fill_level);
            else passed++;
        total++; if (accepted_count !== 32'd0 || drop_count !== 16'd0 || out_neuron_id !== 8'd0 || out_weight !== 8'd0)
            $display("FAIL reset_values got acc%0d drop%0d id%0d wt%0d want all 0", accepted_count, drop_count, out_neuron_id, out_weight);
            else passed++;
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic_order();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_neuron_id = 8'(i);
            in_weight    = 8'(8'h10 + i);
            step();
            total++;
            if (out_valid !== 1'b1 || out_neuron_id !== 8'(i) || out_weight !== 8'(8'h10 + i))
                $display("FAIL basic_head_%0d got v%0b id%0d wt%h want v1 id%0d wt%h",
                         i, out_valid, out_neuron_id, out_weight, i, 8'(8'h10 + i));
            else passed++;
        end
        in_valid = 1'b0;
        step();
        exp_acc += 4;
        total++; if (fill_level !== 5'd0 || empty !== 1'b1) $display("FAIL basic_drain got l%0d e%0b want l0 e1", fill_level, empty); else passed++;
        total++; if (accepted_count !== 32'(exp_acc)) $display("FAIL basic_acc got %0d want %0d", accepted_count, exp_acc); else passed++;
    endtask

    task automatic test_full();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int k = 0; k < 16; k++) begin
            in_neuron_id = 8'(20 + k);
            in_weight    = 8'(k);
            #1;
            total++; if (in_ready !== 1'b1) $display("FAIL full_ready_%0d got %0b want 1", k, in_ready); else passed++;
            step();
        end
        in_neuron_id = 8'd36; in_weight = 8'hAA;
        #1;
        total++; if (in_ready !== 1'b0 || full !== 1'b1 || fill_level !== 5'd16)
            $display("FAIL full_state got r%0b f%0b l%0d want r0 f1 l16", in_ready, full, fill_level);
            else passed++;
        out_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            total++;
            if (out_neuron_id !== 8'(20 + k) || out_weight !== 8'(k))
                $display("FAIL full_drain_%0d got id%0d wt%0d want id%0d wt%0d", k, out_neuron_id, out_weight, 20 + k, k);
            else passed++;
            if (k == 0) begin
                #1;
                total++; if (in_ready !== 1'b0) $display("FAIL full_pop_same_cycle got %0b want 0", in_ready); else passed++;
            end
            step();
            if (k == 1) in_valid = 1'b0;
        end
        total++; if (out_valid !== 1'b1 || out_neuron_id !== 8'd36 || out_weight !== 8'hAA)
            $display("FAIL full_17th got v%0b id%0d wt%h want v1 id36 wtaa", out_valid, out_neuron_id, out_weight);
            else passed++;
        step();
        exp_acc += 17;
        total++; if (empty !== 1'b1 || accepted_count !== 32'(exp_acc))
            $display("FAIL full_final got e%0b acc%0d want e1 acc%0d", empty, accepted_count, exp_acc);
            else passed++;
    endtask

    task automatic test_range();
        clr_stats = 1'b1;
        step();
        clr_stats = 1'b0;
        exp_acc = 0;
        total++; if (accepted_count !== 32'd0 || drop_count !== 16'd0)
            $display("FAIL clr_stats got acc%0d drop%0d want 0 0", accepted_count, drop_count);
            else passed++;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_neuron_id = 8'd63;  in_weight = 8'h01; step();
        in_neuron_id = 8'd64;  in_weight = 8'h02; step();
        in_neuron_id = 8'd255; in_weight = 8'h03; step();
        in_valid = 1'b0;
        exp_acc = 1;
        total++; if (fill_level !== 5'd1 || out_neuron_id !== 8'd63 || out_weight !== 8'h01)
            $display("FAIL range_store got l%0d id%0d wt%h want l1 id63 wt01", fill_level, out_neuron_id, out_weight);
            else passed++;
        total++; if (drop_count !== 16'd2 || accepted_count !== 32'd1)
            $display("FAIL range_counts got drop%0d acc%0d want 2 1", drop_count, accepted_count);
            else passed++;
        out_ready = 1'b1;
        step();
        in_valid = 1'b1; in_neuron_id = 8'd200;
        for (int i = 0; i < 70000; i++) step();
        total++; if (drop_count !== 16'hFFFF || fill_level !== 5'd0)
            $display("FAIL drop_saturate got drop%h l%0d want ffff l0", drop_count, fill_level);
            else passed++;
        clr_stats = 1'b1;
        step();
        clr_stats = 1'b0; in_valid = 1'b0;
        total++; if (drop_count !== 16'd0) $display("FAIL clr_vs_inc got %0d want 0", drop_count); else passed++;
        exp_acc = 0;
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        push_n(5, 1, 8'h50);
        exp_acc += 5;
        total++; if (fill_level !== 5'd5) $display("FAIL flush_pre got %0d want 5", fill_level); else passed++;
        flush = 1'b1; in_valid = 1'b1; in_neuron_id = 8'd9; out_ready = 1'b1;
        #1;
        total++; if (in_ready !== 1'b0) $display("FAIL flush_in_ready got %0b want 0", in_ready); else passed++;
        step();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        total++; if (empty !== 1'b1 || fill_level !== 5'd0 || out_valid !== 1'b0)
            $display("FAIL flush_empty got e%0b l%0d v%0b want e1 l0 v0", empty, fill_level, out_valid);
            else passed++;
        total++; if (accepted_count !== 32'(exp_acc) || drop_count !== 16'd0)
            $display("FAIL flush_counts got acc%0d drop%0d want %0d 0", accepted_count, drop_count, exp_acc);
            else passed++;
    endtask

    task automatic test_enable();
        out_ready = 1'b0;
        push_n(3, 7, 8'h70);
        exp_acc += 3;
        enable = 1'b0; in_valid = 1'b1; in_neuron_id = 8'd10; out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            total++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_neuron_id !== 8'(7 + k))
                $display("FAIL enable_drain_%0d got r%0b v%0b id%0d want r0 v1 id%0d", k, in_ready, out_valid, out_neuron_id, 7 + k);
            else passed++;
            step();
        end
        total++; if (empty !== 1'b1 || accepted_count !== 32'(exp_acc) || drop_count !== 16'd0)
            $display("FAIL enable_final got e%0b acc%0d drop%0d want e1 %0d 0", empty, accepted_count, drop_count, exp_acc);
            else passed++;
        enable = 1'b1; in_valid = 1'b0;
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        in_valid = 1'b1; in_neuron_id = 8'd99; step();
        push_n(8, 30, 8'h00);
        in_valid = 1'b1; in_neuron_id = 8'd40;
        total++; if (fill_level !== 5'd8 || drop_count !== 16'd1)
            $display("FAIL areset_pre got l%0d drop%0d want 8 1", fill_level, drop_count);
            else passed++;
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0 || full !== 1'b0 || fill_level !== 5'd0 ||
                     accepted_count !== 32'd0 || drop_count !== 16'd0 || in_ready !== 1'b0)
            $display("FAIL areset_clear got v%0b f%0b l%0d acc%0d drop%0d r%0b want all 0",
                     out_valid, full, fill_level, accepted_count, drop_count, in_ready);
            else passed++;
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_basic_order();
        test_full();
        test_range();
        test_flush();
        test_enable();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
